// File: rtl/accum_32_bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_32_bit_pkg
// Description : Shared opcodes, FSM encoding and saturation limits for the
//               accum_32_bit accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_32_bit_pkg;

  localparam int ACC_W = 32;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed extremes used as clamp targets when saturation is built in
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/accum_32_bit_add_sub_32.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_32
// Description : Combinational add/subtract built from two WIDTH/2 ripple
//               halves; reports carry-out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] w_b;
  logic [HALF-1:0]  w_sum_lo;
  logic [HALF-1:0]  w_sum_hi;
  logic             w_c_mid;
  logic             w_c_out;

  // Subtraction is a + ~b + 1; the +1 enters as carry-in of the low half
  assign w_b = b ^ {WIDTH{sub}};

  assign {w_c_mid, w_sum_lo} = {1'b0, a[HALF-1:0]} + {1'b0, w_b[HALF-1:0]}
                             + {{HALF{1'b0}}, sub};
  assign {w_c_out, w_sum_hi} = {1'b0, a[WIDTH-1:HALF]} + {1'b0, w_b[WIDTH-1:HALF]}
                             + {{HALF{1'b0}}, w_c_mid};

  assign sum  = {w_sum_hi, w_sum_lo};
  assign cout = w_c_out;
  assign ovf  = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/accum_32_bit.sv
`default_nettype none
// ============================================================================
// Module      : accum_32_bit
// Description : Handshaked 32-bit accumulator (ADD/SUB/LOAD/CLEAR) wrapping
//               add_sub_32. Define ACCUM_SATURATE_EN to clamp acc on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_32_bit
  import accum_32_bit_pkg::*;
#(
  parameter int WIDTH = ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf,
  output logic             ovf_sticky
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_ovf;
  logic             r_sticky;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_arith;
  logic             w_cout;
  logic             w_ovf;

  add_sub_32 #(.WIDTH(WIDTH)) u_add_sub (
    .a    (r_acc),
    .b    (r_data),
    .sub  (r_op == OP_SUB),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

`ifdef ACCUM_SATURATE_EN
  localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Overflow can only occur with like-signed operands, so acc's sign gives direction
  assign w_arith = w_ovf ? (r_acc[WIDTH-1] ? c_SAT_MIN : c_SAT_MAX) : w_sum;
`else
  assign w_arith = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = EXEC;
      end
      EXEC: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_op   <= OP_ADD;
    end else if (r_state == IDLE && in_valid) begin
      r_data <= in_data;
      r_op   <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
    end else if (r_state == EXEC) begin
      case (r_op)
        OP_ADD, OP_SUB: begin
          r_acc    <= w_arith;
          r_carry  <= w_cout;
          r_ovf    <= w_ovf;
          r_sticky <= r_sticky | w_ovf;
        end
        OP_LOAD: begin
          r_acc   <= r_data;
          r_carry <= 1'b0;
          r_ovf   <= 1'b0;
        end
        default: begin
          r_acc    <= '0;
          r_carry  <= 1'b0;
          r_ovf    <= 1'b0;
          r_sticky <= 1'b0;
        end
      endcase
    end
  end

  assign acc        = r_acc;
  assign carry      = r_carry;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule
`default_nettype wire
